mem_access_unit: RTL and testbench

Load/store unit between the pipeline MEM stage and the word-addressed `data_memory`. It accepts one byte, halfword or word request at a time and converts byte addresses to word indices. It performs read-modify-write for sub-word stores, since memory only writes whole words. It also extracts and sign- or zero-extends loaded data, and stalls the pipeline until the access completes.

---
 rtl/mau_pkg.sv | 20 ++
 rtl/mau_lane.sv | 41 ++++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and size normalisation.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } mau_state_e;

  // The reserved size code behaves as a word access when it is not trapped.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SZ_WORD : size;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Big-endian lane logic: extracts and extends load data, and merges store data into a word.
module mau_lane
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Big-endian: byte k sits 8*(3-k) bits up; the half at offset 0 sits 16 bits up.
  assign byte_sh  = {~offset, 3'b000};
  assign half_sh  = {~offset[1], 4'b0000};
  assign byte_val = 8'(word >> byte_sh);
  assign half_val = 16'(word >> half_sh);

  always_comb begin
    load_data = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = is_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
        merged    = (word & ~(32'h0000_00FF << byte_sh)) | ({24'h0, wdata[7:0]} << byte_sh);
      end
      SZ_HALF: begin
        load_data = is_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
        merged    = (word & ~(32'h0000_FFFF << half_sh)) | ({16'h0, wdata[15:0]} << half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit with read-modify-write for sub-word stores.
// Define MAU_ALIGN_TRAP_EN to trap misaligned and reserved-size requests with resp_err.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RD    | reading the addressed word from memory
// WR    | writing the full (possibly merged) word
// RESP  | one-cycle response pulse
module mem_access_unit
  import mau_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  mau_state_e  state;
  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [1:0]  size_n;
  logic        trap;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign size_n = norm_size(req_size);

`ifdef MAU_ALIGN_TRAP_EN
  assign trap = (req_size == 2'b11) ||
                ((req_size == SZ_HALF) && req_addr[0]) ||
                ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE);
  assign resp_err  = err_q;

  // Lane logic works straight off mem_rdata so the RD cycle can register the result.
  mau_lane u_lane (
    .size        (size_q),
    .offset      (off_q),
    .is_unsigned (uns_q),
    .word        (mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      err_q      <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            uns_q   <= req_unsigned;
            size_q  <= size_n;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (trap) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= 32'h0;
              err_q      <= 1'b1;
            end else begin
              mem_addr <= {2'b00, req_addr[31:2]};
              if (req_write && (size_n == SZ_WORD)) begin
                state     <= WR;
                mem_write <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state    <= RD;
                mem_read <= 1'b1;
              end
            end
          end
        end
        RD: begin
          mem_read <= 1'b0;
          if (wr_q) begin
            // The captured word, with the target lane replaced, is what gets written back.
            state     <= WR;
            mem_write <= 1'b1;
            mem_wdata <= merged;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
            err_q      <= 1'b0;
          end
        end
        WR: begin
          mem_write  <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= 32'h0;
          err_q      <= 1'b0;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array reference model, combinational memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .stall        (stall),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Memory seen by the DUT: 16 words, decoded on the low index bits.
  logic [31:0] mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'h0;
  logic [31:0] pre_val = 32'h0;

  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    bit          rd;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          off;
  } wexp_t;

  exp_t        sq[$];
  wexp_t       wq[$];
  logic [31:0] ref_mem [16];
  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexp(input string name);
    tests++;
    failed++;
    $display("FAIL %s: got an event, expected none (t=%0t)", name, $time);
  endtask

  // Reference model: memory words viewed as big-endian byte arrays.
  task automatic push_model(input bit w, input logic [1:0] sz, input bit u,
                            input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    wexp_t       x;
    logic [7:0]  b [4];
    logic [31:0] v;
    logic [1:0]  esz;
    int          idx, k, h;
    bit          trap;
    trap = 1'b0;
`ifdef MAU_ALIGN_TRAP_EN
    trap = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`endif
    esz = (sz == 2'b11) ? 2'b10 : sz;
    idx = int'(a[5:2]);
    k   = int'(a[1:0]);
    h   = int'(a[1]);
    for (int i = 0; i < 4; i++) b[i] = 8'(ref_mem[idx] >> (24 - 8 * i));
    e.addr  = {2'b00, a[31:2]};
    e.err   = 1'b0;
    e.rdata = 32'h0;
    if (trap) begin
      e.err = 1'b1;
      e.lat = 1;
      e.rd  = 1'b0;
    end else if (!w) begin
      e.rd  = 1'b1;
      e.lat = 2;
      case (esz)
        2'b00: begin
          v = {24'h0, b[k]};
          if (!u && b[k][7]) v = v | 32'hFFFF_FF00;
        end
        2'b01: begin
          v = {16'h0, b[2*h], b[2*h+1]};
          if (!u && b[2*h][7]) v = v | 32'hFFFF_0000;
        end
        default: v = ref_mem[idx];
      endcase
      e.rdata = v;
    end else begin
      if (esz == 2'b10) begin
        e.rd  = 1'b0;
        e.lat = 2;
        x.off = 1;
        ref_mem[idx] = wd;
      end else begin
        e.rd  = 1'b1;
        e.lat = 3;
        x.off = 2;
        if (esz == 2'b00) b[k] = wd[7:0];
        else begin
          b[2*h]   = wd[15:8];
          b[2*h+1] = wd[7:0];
        end
        ref_mem[idx] = {b[0], b[1], b[2], b[3]};
      end
      x.addr = e.addr;
      x.data = ref_mem[idx];
      wq.push_back(x);
    end
    sq.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT shows a memory strobe or a response.
  always @(negedge clk) begin : monitor
    exp_t  e;
    wexp_t x;
    cyc++;
    if (!rst) begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (mem_read || mem_write) chk("strobe_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
      if (mem_read) begin
        if (sq.size() == 0) unexp("mem_read_unexpected");
        else begin
          chk("rd_expected", {31'h0, sq[0].rd}, 32'h1);
          chk("rd_addr", mem_addr, sq[0].addr);
          chk("rd_cycle", 32'(cyc - acc_cyc), 32'd1);
        end
      end
      if (mem_write) begin
        if (wq.size() == 0) unexp("mem_write_unexpected");
        else begin
          x = wq.pop_front();
          chk("wr_addr", mem_addr, x.addr);
          chk("wr_data", mem_wdata, x.data);
          chk("wr_cycle", 32'(cyc - acc_cyc), 32'(x.off));
        end
      end
      if (resp_valid) begin
        if (sq.size() == 0) unexp("resp_unexpected");
        else begin
          e = sq.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          chk("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
          last_rdata = resp_rdata;
          last_err   = resp_err;
        end
      end
    end
  end

  task automatic drive(input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd);
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sq.size() != 0 || wq.size() != 0) && n < 12) begin
      @(posedge clk);
      n++;
    end
    if (sq.size() != 0 || wq.size() != 0) begin
      unexp("drain_timeout");
      sq.delete();
      wq.delete();
    end
  endtask

  task automatic do_req(input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] wd);
    push_model(w, sz, u, a, wd);
    @(posedge clk); #1;
    drive(w, sz, u, a, wd);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain();
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    @(posedge clk); #1;
    pre_en  = 1'b1;
    pre_idx = 4'(idx);
    pre_val = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) preload(i, $urandom);

    // Word store then load
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("plan_word_load", last_rdata, 32'hDEADBEEF);

    // Byte/half loads with extension
    preload(4, 32'h1280FF34);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("plan_byte_signed", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("plan_byte_unsigned", last_rdata, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("plan_half_signed", last_rdata, 32'hFFFFFF34);

    // Sub-word store read-modify-write
    preload(4, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AB);
    chk("plan_rmw_mem", mem[4], 32'h112233AB);

    // Misaligned word load
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
`ifdef MAU_ALIGN_TRAP_EN
    chk("plan_misalign_err", {31'h0, last_err}, 32'h1);
`else
    chk("plan_misalign_noerr", {31'h0, last_err}, 32'h0);
    chk("plan_misalign_data", last_rdata, 32'h112233AB);
`endif

    // Top of the address space
    do_req(1'b0, 2'b10, 1'b1, 32'hFFFFFFFC, 32'h0);

    // Back-pressure: req_valid held through a load, second request waits
    push_model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    push_model(1'b0, 2'b00, 1'b0, 32'h15, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    req_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready_c0", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 1'b0, 32'h15, 32'h0);
    @(negedge clk);
    chk("bp_busy_c1", {30'h0, req_ready, stall}, 32'h1);
    @(negedge clk);
    chk("bp_busy_c2", {30'h0, req_ready, stall}, 32'h1);
    @(negedge clk);
    chk("bp_ready_c3", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain();

    // Reset during the RD cycle of a sub-word store
    preload(5, 32'hCAFEF00D);
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 1'b0, 32'h15, 32'h00000055);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_midop_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    chk("rst_midop_nowrite", mem[5], 32'hCAFEF00D);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             32'($urandom_range(0, 63)), $urandom);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

endmodule
